// File: rtl/unsigned_sequential_divider.sv
// rtl/unsigned_sequential_divider.sv - restoring unsigned divider, one quotient bit per clock
`timescale 1ns/1ps

module unsigned_sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // The partial remainder is always below the divisor, so it fits in WIDTH bits;
    // only the shifted trial value needs the extra top bit for the compare.
    always_comb begin
        trial  = {r, q[WIDTH-1]};
        fits   = trial >= {1'b0, divisor};
        diff   = trial[WIDTH-1:0] - divisor;
        q_next = {q[WIDTH-2:0], fits};
        r_next = fits ? diff : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            divisor     <= '0;
            q           <= '0;
            r           <= '0;
            count       <= '0;
            quo         <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            divisor <= b;
                            q       <= a;
                            r       <= '0;
                            count   <= CW'(WIDTH);
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            quo         <= '1;
                            rem         <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q     <= q_next;
                    r     <= r_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        quo         <= q_next;
                        rem         <= r_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_sequential_divider.sv
// tb/tb_unsigned_sequential_divider.sv - self-checking bench for unsigned_sequential_divider
`timescale 1ns/1ps

module tb_unsigned_sequential_divider;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;
    logic [7:0] last_quo = '0;
    logic [7:0] last_rem = '0;

    unsigned_sequential_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .quo         (quo),
        .rem         (rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a division at a negedge, scrambles the operand inputs while it runs and
    // returns at the negedge of the done cycle so a following call is back-to-back.
    task automatic run_div(input logic [7:0] aa, input logic [7:0] bb, input string tag);
        int lat;
        int exp_q;
        int exp_r;
        int qi;
        int ri;
        if (bb == 0) begin
            exp_q = 255;
            exp_r = aa;
        end else begin
            exp_q = aa / bb;
            exp_r = aa % bb;
        end
        a = aa;
        b = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            check({tag, " busy"}, busy, 1);
            check({tag, " quo_hold"}, quo, last_quo);
            check({tag, " rem_hold"}, rem, last_rem);
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, (bb == 0) ? 0 : 8);
        check({tag, " done"}, done, 1);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " quo"}, quo, exp_q);
        check({tag, " rem"}, rem, exp_r);
        check({tag, " dbz"}, div_by_zero, (bb == 0) ? 1 : 0);
        if (bb != 0) begin
            qi = quo;
            ri = rem;
            check({tag, " identity"}, qi * bb + ri, aa);
            check({tag, " rem_lt_b"}, (ri < bb) ? 1 : 0, 1);
        end
        last_quo = 8'(exp_q);
        last_rem = 8'(exp_r);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " quo"}, quo, 0);
        check({tag, " rem"}, rem, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " dbz"}, div_by_zero, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1 plus single-cycle done pulse
        run_div(8'd229, 8'd21, "t1");
        @(negedge clk);
        check("t1 done_pulse", done, 0);

        // T2 back-to-back: second start issued in the done cycle
        run_div(8'd213, 8'd2, "t2a");
        run_div(8'd192, 8'd63, "t2b");
        @(negedge clk);

        // T3 edge operands
        run_div(8'd255, 8'd1, "t3a");
        run_div(8'd55, 8'd128, "t3b");
        run_div(8'd0, 8'd7, "t3c");
        @(negedge clk);

        // T4 divide by zero then a normal division clears the flag
        run_div(8'd200, 8'd0, "t4a");
        @(negedge clk);
        check("t4 done_pulse", done, 0);
        check("t4 busy_after", busy, 0);
        run_div(8'd240, 8'd204, "t4b");
        @(negedge clk);

        // T5a start while busy is ignored
        a = 8'd229;
        b = 8'd21;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            if (lat == 3) begin
                a = 8'd10;
                b = 8'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("t5a latency", lat, 8);
        check("t5a quo", quo, 10);
        check("t5a rem", rem, 19);
        last_quo = 8'd10;
        last_rem = 8'd19;
        @(negedge clk);

        // T5b asynchronous reset mid-run discards the division
        a = 8'd50;
        b = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("t5b in_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("t5b no_done", done, 0);
            check("t5b idle", busy, 0);
        end
        last_quo = '0;
        last_rem = '0;
        run_div(8'd100, 8'd7, "t5c");
        @(negedge clk);

        // T6 random sweep
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_div(ra, rb, "t6");
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
